// File: rtl/countdown_pkg.sv
// Shared types, limits and helpers for the MM:SS.cc countdown timer.
package countdown_pkg;

    // Default parameter values for a 50 MHz board clock.
    localparam int DEFAULT_CLKS_PER_TICK   = 500000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int DEFAULT_BLINK_TICKS     = 50;

    // BCD digit limits: tens of seconds/minutes stop at 5, everything else at 9.
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_PAUSED,
        ST_EXPIRED
    } state_t;

    // Displayed count, most significant digit first.
    typedef struct packed {
        logic [3:0] minute_high;
        logic [3:0] minute_low;
        logic [3:0] second_high;
        logic [3:0] second_low;
        logic [3:0] msecond_high;
        logic [3:0] msecond_low;
    } bcd_time_t;

    // Saturate a switch digit to the largest legal value for its position.
    function automatic logic [3:0] clamp_digit(input logic [3:0] digit, input logic [3:0] limit);
        return (digit > limit) ? limit : digit;
    endfunction

    // Build the value loaded from the switches: clamped MM:SS with centiseconds 00.
    function automatic bcd_time_t preset_time(input logic [7:0] minutes, input logic [7:0] seconds);
        bcd_time_t t;
        t.minute_high  = clamp_digit(minutes[7:4], SEC_TENS_MAX);
        t.minute_low   = clamp_digit(minutes[3:0], DIGIT_MAX);
        t.second_high  = clamp_digit(seconds[7:4], SEC_TENS_MAX);
        t.second_low   = clamp_digit(seconds[3:0], DIGIT_MAX);
        t.msecond_high = 4'd0;
        t.msecond_low  = 4'd0;
        return t;
    endfunction

    // Subtract one centisecond with a ripple borrow; 00:00.00 is held, never wrapped.
    function automatic bcd_time_t bcd_decrement(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t != '0) begin
            if (t.msecond_low != 4'd0) begin
                r.msecond_low = t.msecond_low - 4'd1;
            end else begin
                r.msecond_low = DIGIT_MAX;
                if (t.msecond_high != 4'd0) begin
                    r.msecond_high = t.msecond_high - 4'd1;
                end else begin
                    r.msecond_high = DIGIT_MAX;
                    if (t.second_low != 4'd0) begin
                        r.second_low = t.second_low - 4'd1;
                    end else begin
                        r.second_low = DIGIT_MAX;
                        if (t.second_high != 4'd0) begin
                            r.second_high = t.second_high - 4'd1;
                        end else begin
                            r.second_high = SEC_TENS_MAX;
                            if (t.minute_low != 4'd0) begin
                                r.minute_low = t.minute_low - 4'd1;
                            end else begin
                                // All lower digits are zero and t is nonzero,
                                // so minute_high is guaranteed to be at least 1.
                                r.minute_low  = DIGIT_MAX;
                                r.minute_high = t.minute_high - 4'd1;
                            end
                        end
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer, low-level run counter and one-shot for an active-low key.
// Emits exactly one registered pulse per qualified press; a held key never repeats.
module key_debounce
    import countdown_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic pulse
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_ARM = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_key;
    logic [CW-1:0] count;

    // Bring the asynchronous pin into the clk domain; released (1) out of reset.
    always_ff @(posedge clk) begin
        // NOTE: every sequential assignment is non-blocking so each flop samples
        // the pre-edge value of its neighbour, which is what makes this a 2-stage shift.
        if (reset) begin
            sync_meta <= 1'b1;
            sync_key  <= 1'b1;
        end else begin
            sync_meta <= key;
            sync_key  <= sync_meta;
        end
    end

    // Count consecutive low samples, saturate at the threshold, fire once on arrival.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= !sync_key && (count == CNT_ARM);
            if (sync_key) begin
                count <= '0;
            end else if (count != CNT_MAX) begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Down-counting MM:SS.cc timer: preset load, start/pause, expiry alarm blink.
// Drives six BCD digits for the board's seven-segment decoders.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int CLKS_PER_TICK   = DEFAULT_CLKS_PER_TICK,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int BLINK_TICKS     = DEFAULT_BLINK_TICKS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_load,
    input  logic       key_start_pause,
    input  logic [7:0] preset_min,
    input  logic [7:0] preset_sec,
    output logic [3:0] minute_high,
    output logic [3:0] minute_low,
    output logic [3:0] second_high,
    output logic [3:0] second_low,
    output logic [3:0] msecond_high,
    output logic [3:0] msecond_low,
    output logic       running,
    output logic       expired,
    output logic       alarm_led
);

    localparam int            PW         = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_TICK - 1);
    localparam int            BW         = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic          load_pulse;
    logic          start_pulse;

    state_t        state;
    state_t        state_next;
    bcd_time_t     count;
    bcd_time_t     count_next;
    bcd_time_t     count_dec;

    logic [PW-1:0] presc;
    logic          presc_clear;
    logic          tick;

    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_next;
    logic          alarm_next;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load_key (
        .clk   (clk),
        .reset (reset),
        .key   (key_load),
        .pulse (load_pulse)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start_key (
        .clk   (clk),
        .reset (reset),
        .key   (key_start_pause),
        .pulse (start_pulse)
    );

    assign tick      = (presc == PRESC_LAST);
    assign count_dec = bcd_decrement(count);

    // 10 ms prescaler; restarts from zero whenever the timer (re)enters RUNNING.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (presc_clear || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Next-state, count and alarm decisions; load beats start, any pulse beats a tick.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_next  = state;
        count_next  = count;
        blink_next  = blink_cnt;
        alarm_next  = alarm_led;
        presc_clear = 1'b0;

        if (load_pulse) begin
            state_next = ST_IDLE;
            count_next = preset_time(preset_min, preset_sec);
            blink_next = '0;
            alarm_next = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_pulse && (count != '0)) begin
                        state_next  = ST_RUNNING;
                        presc_clear = 1'b1;
                    end
                end
                ST_RUNNING: begin
                    if (start_pulse) begin
                        state_next = ST_PAUSED;
                    end else if (tick) begin
                        count_next = count_dec;
                        if (count_dec == '0) begin
                            state_next = ST_EXPIRED;
                            alarm_next = 1'b1;
                            blink_next = '0;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (start_pulse) begin
                        state_next  = ST_RUNNING;
                        presc_clear = 1'b1;
                    end
                end
                ST_EXPIRED: begin
                    if (start_pulse) begin
                        state_next = ST_IDLE;
                        alarm_next = 1'b0;
                        blink_next = '0;
                    end else if (tick) begin
                        if (blink_cnt == BLINK_LAST) begin
                            blink_next = '0;
                            alarm_next = !alarm_led;
                        end else begin
                            blink_next = blink_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State, count and alarm registers; status flags are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            blink_cnt <= '0;
            alarm_led <= 1'b0;
            running   <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            blink_cnt <= blink_next;
            alarm_led <= alarm_next;
            running   <= (state_next == ST_RUNNING);
            expired   <= (state_next == ST_EXPIRED);
        end
    end

    assign minute_high  = count.minute_high;
    assign minute_low   = count.minute_low;
    assign second_high  = count.second_high;
    assign second_low   = count.second_low;
    assign msecond_high = count.msecond_high;
    assign msecond_low  = count.msecond_low;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random key/reset
// traffic, compared every cycle against a centisecond-arithmetic reference model.
module tb_countdown_timer;

    localparam int CPT = 4;
    localparam int DB  = 3;
    localparam int BT  = 2;

    localparam int M_IDLE    = 0;
    localparam int M_RUNNING = 1;
    localparam int M_PAUSED  = 2;
    localparam int M_EXPIRED = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_load = 1'b1;
    logic       key_start_pause = 1'b1;
    logic [7:0] preset_min = 8'h00;
    logic [7:0] preset_sec = 8'h00;
    logic [3:0] minute_high, minute_low, second_high, second_low, msecond_high, msecond_low;
    logic       running, expired, alarm_led;

    int n_tests  = 0;
    int n_failed = 0;

    always #5 clk = ~clk;

    countdown_timer #(
        .CLKS_PER_TICK   (CPT),
        .DEBOUNCE_CYCLES (DB),
        .BLINK_TICKS     (BT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .key_load        (key_load),
        .key_start_pause (key_start_pause),
        .preset_min      (preset_min),
        .preset_sec      (preset_sec),
        .minute_high     (minute_high),
        .minute_low      (minute_low),
        .second_high     (second_high),
        .second_low      (second_low),
        .msecond_high    (msecond_high),
        .msecond_low     (msecond_low),
        .running         (running),
        .expired         (expired),
        .alarm_led       (alarm_led)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Time is held as total centiseconds; a press is recognised once the pin has
    // been seen low on DB consecutive edges and appears two edges later.
    int m_state = M_IDLE;
    int m_cs = 0;
    int m_presc = 0;
    int m_exp_ticks = 0;
    bit m_alarm = 1'b0;
    bit m_ld_pulse = 1'b0, m_st_pulse = 1'b0;
    int m_ld_r1 = 0, m_ld_r2 = 0, m_st_r1 = 0, m_st_r2 = 0;
    bit model_valid = 1'b0;

    function automatic int clamp(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic int preset_cs(input logic [7:0] mn, input logic [7:0] sc);
        int mins, secs;
        mins = clamp(int'(mn[7:4]), 5) * 10 + clamp(int'(mn[3:0]), 9);
        secs = clamp(int'(sc[7:4]), 5) * 10 + clamp(int'(sc[3:0]), 9);
        return mins * 6000 + secs * 100;
    endfunction

    task automatic model_step();
        bit ld, st, tick, enter_run;
        int run_ld, run_st;
        if (reset) begin
            m_state = M_IDLE; m_cs = 0; m_presc = 0; m_exp_ticks = 0; m_alarm = 0;
            m_ld_pulse = 0; m_st_pulse = 0;
            m_ld_r1 = 0; m_ld_r2 = 0; m_st_r1 = 0; m_st_r2 = 0;
            return;
        end
        ld = m_ld_pulse;
        st = m_st_pulse;
        tick = (m_presc == CPT - 1);
        enter_run = 1'b0;
        if (ld) begin
            m_state = M_IDLE;
            m_cs = preset_cs(preset_min, preset_sec);
            m_alarm = 1'b0;
        end else begin
            case (m_state)
                M_IDLE: if (st && m_cs != 0) begin m_state = M_RUNNING; enter_run = 1'b1; end
                M_RUNNING: begin
                    if (st) m_state = M_PAUSED;
                    else if (tick) begin
                        m_cs = m_cs - 1;
                        if (m_cs == 0) begin
                            m_state = M_EXPIRED; m_exp_ticks = 0; m_alarm = 1'b1;
                        end
                    end
                end
                M_PAUSED: if (st) begin m_state = M_RUNNING; enter_run = 1'b1; end
                default: begin
                    if (st) begin m_state = M_IDLE; m_alarm = 1'b0; end
                    else if (tick) begin
                        m_exp_ticks++;
                        m_alarm = ((m_exp_ticks / BT) % 2) == 0;
                    end
                end
            endcase
        end
        m_presc = enter_run ? 0 : (m_presc + 1) % CPT;
        run_ld = key_load ? 0 : ((m_ld_r1 < 1000) ? m_ld_r1 + 1 : 1000);
        run_st = key_start_pause ? 0 : ((m_st_r1 < 1000) ? m_st_r1 + 1 : 1000);
        m_ld_pulse = (m_ld_r2 == DB);
        m_st_pulse = (m_st_r2 == DB);
        m_ld_r2 = m_ld_r1; m_ld_r1 = run_ld;
        m_st_r2 = m_st_r1; m_st_r1 = run_st;
    endtask

    function automatic logic [31:0] model_vec();
        int mins, secs, cc;
        mins = m_cs / 6000;
        secs = (m_cs / 100) % 60;
        cc   = m_cs % 100;
        return {5'd0, 4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
                4'(cc / 10), 4'(cc % 10), m_state == M_RUNNING, m_state == M_EXPIRED, m_alarm};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {5'd0, minute_high, minute_low, second_high, second_low,
                msecond_high, msecond_low, running, expired, alarm_led};
    endfunction

    function automatic logic [31:0] dut_digits();
        return {8'd0, minute_high, minute_low, second_high, second_low, msecond_high, msecond_low};
    endfunction

    always @(posedge clk) begin
        model_step();
        model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) check("cycle_vs_model", dut_vec(), model_vec());
    end

    // ---------------- stimulus ----------------
    task automatic press(input bit on_load, input bit on_start, input int low_cycles);
        @(negedge clk);
        if (on_load)  key_load = 1'b0;
        if (on_start) key_start_pause = 1'b0;
        repeat (low_cycles) @(negedge clk);
        key_load = 1'b1;
        key_start_pause = 1'b1;
    endtask

    task automatic load_preset(input logic [7:0] mn, input logic [7:0] sc);
        preset_min = mn;
        preset_sec = sc;
        press(1'b1, 1'b0, 6);
    endtask

    initial begin
        int pulses, pulse_edge, waited, ld_left, st_left;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_state", dut_vec(), 32'd0);

        // 1: single load pulse at edge 5 after the key falls
        preset_min = 8'h01; preset_sec = 8'h05;
        key_load = 1'b0;
        pulses = 0; pulse_edge = 0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            if (dut.load_pulse) begin pulses++; pulse_edge = e; end
        end
        @(negedge clk);
        key_load = 1'b1;
        check("load_pulse_count", pulses, 1);
        check("load_pulse_edge", pulse_edge, 5);
        check("load_0105_digits", dut_digits(), 32'h010500);
        check("load_idle_flags", {running, expired, alarm_led}, 3'b000);

        // 2: 00:01 runs 100 ticks to expiry, then the alarm blinks
        load_preset(8'h00, 8'h01);
        press(1'b0, 1'b1, 6);
        check("start_running", running, 1'b1);
        waited = 0;
        while (!expired && waited < 2000) begin @(negedge clk); waited++; end
        check("expire_latency", waited, 400);
        check("expired_vec", dut_vec(), 32'h0000_0003);
        repeat (8) @(negedge clk);
        check("alarm_off_2ticks", alarm_led, 1'b0);
        repeat (8) @(negedge clk);
        check("alarm_on_4ticks", alarm_led, 1'b1);
        press(1'b0, 1'b1, 6);
        check("ack_to_idle", dut_vec(), 32'd0);

        // 3: full borrow chain, pause hold, resume timing
        load_preset(8'h10, 8'h00);
        press(1'b0, 1'b1, 6);
        repeat (4) @(negedge clk);
        check("borrow_chain", dut_digits(), 32'h095999);
        press(1'b0, 1'b1, 6);
        check("paused_flag", running, 1'b0);
        repeat (40) @(negedge clk);
        check("pause_hold", dut_digits(), 32'h095998);
        press(1'b0, 1'b1, 6);
        check("resume_flag", running, 1'b1);
        repeat (3) @(negedge clk);
        check("resume_pre_tick", dut_digits(), 32'h095998);
        @(negedge clk);
        check("resume_first_tick", dut_digits(), 32'h095997);

        // 4: clamp on load
        load_preset(8'h7C, 8'hAF);
        check("clamp_preset", dut_digits(), 32'h595900);
        check("clamp_idle", running, 1'b0);

        // 5: start on zero count; load+start together
        load_preset(8'h00, 8'h00);
        press(1'b0, 1'b1, 6);
        repeat (5) @(negedge clk);
        check("start_on_zero", {running, expired}, 2'b00);
        load_preset(8'h00, 8'h30);
        press(1'b0, 1'b1, 6);
        check("start_30s", running, 1'b1);
        preset_sec = 8'h20;
        press(1'b1, 1'b1, 6);
        repeat (10) @(negedge clk);
        check("load_wins_flag", running, 1'b0);
        check("load_wins_digits", dut_digits(), 32'h002000);

        // 6: bounce rejected; reset mid-run and mid-debounce
        @(negedge clk); key_start_pause = 1'b0;
        repeat (2) @(negedge clk); key_start_pause = 1'b1;
        @(negedge clk); key_start_pause = 1'b0;
        repeat (2) @(negedge clk); key_start_pause = 1'b1;
        repeat (10) @(negedge clk);
        check("bounce_rejected", running, 1'b0);
        press(1'b0, 1'b1, 6);
        repeat (10) @(negedge clk);
        key_load = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_mid_run", dut_vec(), 32'd0);
        reset = 1'b0;
        key_load = 1'b1;
        repeat (10) @(negedge clk);
        check("reset_drops_partial_press", dut_vec(), 32'd0);

        // random phase: short presets, random key activity, rare resets
        ld_left = 0; st_left = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (ld_left == 0 && $urandom_range(0, 79) == 0) begin
                ld_left = $urandom_range(1, 8);
                preset_min = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
                preset_sec = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 2));
            end
            if (st_left == 0 && $urandom_range(0, 29) == 0) st_left = $urandom_range(1, 8);
            key_load = (ld_left == 0);
            key_start_pause = (st_left == 0);
            if (ld_left > 0) ld_left--;
            if (st_left > 0) st_left--;
            reset = ($urandom_range(0, 999) == 0);
        end
        reset = 1'b0;
        key_load = 1'b1;
        key_start_pause = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
